oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Owns the single shared memory port between the sm83 core and the OAM DMA engine.
//  CPU write to 0xFF46 starts a 160-byte copy {src,8'h00} -> 0xFE00..0xFE9F.
//  While DMA runs, the CPU is locked off the bus except for internal HRAM (0xFF80-0xFFFE).
//  Sits between the cpu and the memory model; all CPU traffic passes through.
// PARAMETERS
//  LEN          160  bytes copied per transfer
//  START_DELAY  1    idle cycles between the FF46 write and the first DMA read (>=1)
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  cpu_addr   in   16  CPU address
//  cpu_wdata  in   8   CPU write data
//  cpu_write  in   1   CPU write strobe
//  cpu_rdata  out  8   read data to CPU (combinational)
//  mem_addr   out  16  shared memory address
//  mem_wdata  out  8   shared memory write data
//  mem_write  out  1   shared memory write strobe
//  mem_rdata  in   8   memory read data, valid in the same cycle as mem_addr
//  dma_active out  1   DMA owns the bus (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, dma_reg=8'hFF, dma_active=0, HRAM contents undefined.
//  Address decode (every state):
//   - 0xFF80-0xFFFE: routed to internal HRAM; writes on posedge, async read; never driven to mem.
//   - 0xFF46: write loads dma_reg and (re)starts DMA; read returns dma_reg; never driven to mem.
//  IDLE: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_write=cpu_write (except HRAM/FF46);
//   cpu_rdata=mem_rdata for passthrough addresses.
//  FSM: IDLE -> DLY (START_DELAY cycles) -> RD -> WR -> RD ... -> IDLE.
//   - RD: mem_addr={src_page,idx}, mem_write=0; latch mem_rdata into buf at posedge.
//   - WR: mem_addr=16'hFE00+idx, mem_wdata=buf, mem_write=1; idx++; if idx==LEN-1 -> IDLE.
//   - Total: START_DELAY + 2*LEN cycles with dma_active=1 (321 for defaults).
//  src_page = dma_reg, except dma_reg>=8'hE0 maps to dma_reg-8'h20 (echo RAM mirror).
//  During DMA (non-IDLE): CPU passthrough reads return 8'hFF; CPU passthrough writes dropped.
//  FF46 write in any non-IDLE state: idx<=0, state<=DLY; restart, previous bytes left as written.
//  FF46 write and rst in the same cycle: rst wins.
//  rst mid-transfer: abort next edge; partially copied OAM unchanged; no further mem writes.
//  idx is 8 bits; LEN<=256 is enforced by elaboration assertion.
// STRUCTURE
//  Package gb_mem_pkg: ADDR_DMA=16'hFF46, HRAM_LO/HRAM_HI, OAM_BASE=16'hFE00,
//   dma_state_t enum {IDLE,DLY,RD,WR}, shared with other bus peripherals.
//  Sub-module hram: 127x8, sync write, async read, addressed by cpu_addr[6:0].
//  Top: decode, FSM, idx/delay counters, buf, output muxes.
// TESTING
//  1 Reset, mem[0x1234]=8'h77, CPU reads 0x1234 -> cpu_rdata=77, dma_active=0, FF46 reads FF.
//  2 mem[C000+i]=i; write FF46=C0 -> dma_active=1 for 321 cycles, mem[FE00+i]=i for i<160.
//  3 Mid-DMA: read 0x0100 -> FF; write C000=AA dropped; write FF80=5A then read FF80 -> 5A.
//  4 FF46=C0, at byte 50 write FF46=C1 -> idx restarts at 0, FE00..FE9F == C100..C19F,
//    completion 321 cycles after the second write.
//  5 FF46=FE -> DMA reads 0xDE00..0xDE9F; FF46 read back returns FE.
//  6 rst at byte 80 -> next cycle dma_active=0, FF46=FF, mem_write tracks CPU; FE50.. untouched.

Source files
------------

// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA state encoding for the bus peripherals
// that sit between the sm83 core and the memory model.
package gb_mem_pkg;

  localparam logic [15:0] ADDR_DMA   = 16'hFF46;
  localparam logic [15:0] HRAM_LO    = 16'hFF80;
  localparam logic [15:0] HRAM_HI    = 16'hFFFE;
  localparam logic [15:0] OAM_BASE   = 16'hFE00;
  localparam int          HRAM_DEPTH = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DLY  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } dma_state_t;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

  // Pages E0-FF are echo RAM; the DMA engine sees them as C0-DF.
  function automatic logic [7:0] dma_src_page(input logic [7:0] dma_reg);
    return (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;
  endfunction

endpackage

// File: rtl/hram.sv
// High RAM (FF80-FFFE): 127 bytes, synchronous write, asynchronous read.
// It stays reachable by the CPU while OAM DMA owns the shared bus.
module hram
  import gb_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [0:HRAM_DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: owns the single shared memory port, passes CPU traffic
// through when idle, and copies LEN bytes from {src_page,8'h00} into OAM.
module oam_dma_ctrl
  import gb_mem_pkg::*;
#(
  parameter int LEN         = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output dma_state_t  state_dbg
);

  if (LEN < 1 || LEN > 256) begin : g_len_check
    $error("oam_dma_ctrl: LEN must be in 1..256 (8-bit index)");
  end
  if (START_DELAY < 1 || START_DELAY > 256) begin : g_dly_check
    $error("oam_dma_ctrl: START_DELAY must be in 1..256");
  end

  localparam logic [7:0] IDX_LAST = 8'(LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dly_q, dly_d;
  logic [7:0] dma_reg_q, dma_reg_d;
  logic [7:0] data_buf_q, data_buf_d;

  logic       hit_hram;
  logic       hit_dma;
  logic       passthru;
  logic       dma_reg_wr;
  logic [7:0] src_page;
  logic [7:0] hram_rdata;

  assign hit_hram   = is_hram(cpu_addr);
  assign hit_dma    = (cpu_addr == ADDR_DMA);
  assign passthru   = !hit_hram && !hit_dma;
  assign dma_reg_wr = cpu_write && hit_dma;
  assign src_page   = dma_src_page(dma_reg_q);

  hram u_hram (
    .clk_i   (clk),
    .we_i    (cpu_write && hit_hram),
    .addr_i  (cpu_addr[6:0]),
    .wdata_i (cpu_wdata),
    .rdata_o (hram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dly_d      = dly_q;
    dma_reg_d  = dma_reg_q;
    data_buf_d = data_buf_q;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_write  = 1'b0;

    case (state_q)
      IDLE: begin
        mem_write = cpu_write && passthru;
      end
      DLY: begin
        if (dly_q == DLY_LAST) begin
          dly_d   = 8'd0;
          state_d = RD;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      RD: begin
        mem_addr   = {src_page, idx_q};
        data_buf_d = mem_rdata;
        state_d    = WR;
      end
      WR: begin
        mem_addr  = OAM_BASE + {8'h00, idx_q};
        mem_wdata = data_buf_q;
        mem_write = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = 8'd0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write to FF46 in any state (re)starts the copy from byte 0.
    if (dma_reg_wr) begin
      dma_reg_d = cpu_wdata;
      idx_d     = 8'd0;
      dly_d     = 8'd0;
      state_d   = DLY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      dly_q      <= 8'd0;
      dma_reg_q  <= 8'hFF;
      data_buf_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dly_q      <= dly_d;
      dma_reg_q  <= dma_reg_d;
      data_buf_q <= data_buf_d;
    end
  end

  always_comb begin
    if (hit_hram) begin
      cpu_rdata = hram_rdata;
    end else if (hit_dma) begin
      cpu_rdata = dma_reg_q;
    end else if (state_q == IDLE) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = 8'hFF;
    end
  end

  assign dma_active = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: behavioural 64 KiB memory on the shared port,
// directed CPU traffic, and an expected-value queue drained at each negedge.
module tb_oam_dma_ctrl;
  import gb_mem_pkg::*;

  localparam int K_RDATA  = 0;
  localparam int K_ACTIVE = 1;
  localparam int K_MEM    = 2;
  localparam int K_ACTCNT = 3;
  localparam int K_OAMWR  = 4;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    string       name;
  } chk_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  dma_state_t  state_dbg;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.LEN(160), .START_DELAY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active),
    .state_dbg  (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] = mem_wdata;
  end

  int act_cnt = 0;
  int oam_wr_cnt = 0;

  always @(negedge clk) begin
    if (dma_active) act_cnt++;
  end

  always @(posedge clk) begin
    if (mem_write && mem_addr >= 16'hFE00 && mem_addr <= 16'hFE9F) oam_wr_cnt++;
  end

  // ---------------- scoreboard ----------------
  chk_t        chk_q[$];
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  chk_t        mon_c;
  logic [15:0] mon_exp;
  logic [15:0] mon_act;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_c   = chk_q.pop_front();
      mon_exp = exp_q.pop_front();
      case (mon_c.kind)
        K_RDATA:  mon_act = {8'h00, cpu_rdata};
        K_ACTIVE: mon_act = {15'h0000, dma_active};
        K_MEM:    mon_act = {8'h00, mem[mon_c.addr]};
        K_ACTCNT: mon_act = 16'(act_cnt);
        default:  mon_act = 16'(oam_wr_cnt);
      endcase
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", mon_c.name, mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input int kind, input logic [15:0] addr,
                            input logic [15:0] e, input string name);
    chk_t c;
    c.kind = kind;
    c.addr = addr;
    c.name = name;
    chk_q.push_back(c);
    exp_q.push_back(e);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [7:0] e, input string name);
    cpu_addr  = a;
    cpu_write = 1'b0;
    expect_val(K_RDATA, a, {8'h00, e}, name);
    tick();
  endtask

  task automatic chk_mem(input logic [15:0] a, input logic [7:0] e, input string name);
    expect_val(K_MEM, a, {8'h00, e}, name);
    tick();
  endtask

  task automatic chk_active(input logic e, input string name);
    expect_val(K_ACTIVE, 16'h0000, {15'h0000, e}, name);
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dma_active && n < 2000) begin
      tick();
      n++;
    end
    if (dma_active) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: dma_active still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    rst       = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_write = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      a      = 16'(i);
      mem[i] = a[7:0] ^ a[15:8] ^ 8'h5A;
    end
    mem[16'h1234] = 8'h77;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + i] = 8'(i);
      mem[16'hC100 + i] = 8'(i) ^ 8'hFF;
      mem[16'hDE00 + i] = 8'(i) + 8'h10;
      mem[16'hC200 + i] = 8'(i) + 8'h40;
    end
    tick(2);
    rst = 1'b0;

    // 1: reset state and idle passthrough
    chk_active(1'b0, "t1_rst_active");
    cpu_rd(16'h1234, 8'h77, "t1_pass_rd");
    cpu_rd(16'hFF46, 8'hFF, "t1_dma_reg_rst");
    rst       = 1'b1;
    cpu_addr  = 16'hFF46;
    cpu_wdata = 8'hC0;
    cpu_write = 1'b1;
    tick();
    rst       = 1'b0;
    cpu_write = 1'b0;
    chk_active(1'b0, "t1_rst_wins_active");
    cpu_rd(16'hFF46, 8'hFF, "t1_rst_wins_reg");

    // 2: full copy from page C0
    cpu_wr(16'hFF46, 8'hC0);
    act_cnt = 0;
    chk_active(1'b1, "t2_active");
    wait_idle("t2_done");
    expect_val(K_ACTCNT, 16'h0000, 16'd321, "t2_active_cycles");
    tick();
    chk_mem(16'hFE00, 8'h00, "t2_oam_first");
    chk_mem(16'hFE01, 8'h01, "t2_oam_1");
    chk_mem(16'hFE4F, 8'h4F, "t2_oam_mid");
    chk_mem(16'hFE9F, 8'h9F, "t2_oam_last");
    chk_mem(16'hFEA0, 8'h04, "t2_oam_past_end");

    // 3: CPU lockout except HRAM and FF46 while DMA runs
    cpu_wr(16'hFF46, 8'hC0);
    tick(3);
    cpu_rd(16'h0100, 8'hFF, "t3_locked_rd");
    cpu_wr(16'hC000, 8'hAA);
    cpu_wr(16'hFF80, 8'h5A);
    cpu_rd(16'hFF80, 8'h5A, "t3_hram_rd");
    cpu_rd(16'hFF46, 8'hC0, "t3_dma_reg_rd");
    chk_active(1'b1, "t3_still_active");
    wait_idle("t3_done");
    chk_mem(16'hC000, 8'h00, "t3_write_dropped");
    chk_mem(16'hFE00, 8'h00, "t3_oam_src_intact");
    cpu_rd(16'hFF80, 8'h5A, "t3_hram_idle_rd");
    cpu_rd(16'h0100, 8'h5B, "t3_pass_idle_rd");

    // 4: restart at byte 50 with page C1
    cpu_wr(16'hFF46, 8'hC0);
    tick(101);
    cpu_wr(16'hFF46, 8'hC1);
    act_cnt    = 0;
    oam_wr_cnt = 0;
    wait_idle("t4_done");
    expect_val(K_ACTCNT, 16'h0000, 16'd321, "t4_cycles_after_restart");
    expect_val(K_OAMWR, 16'h0000, 16'd160, "t4_oam_writes");
    tick();
    chk_mem(16'hFE00, 8'hFF, "t4_oam_first");
    chk_mem(16'hFE31, 8'hCE, "t4_oam_49");
    chk_mem(16'hFE32, 8'hCD, "t4_oam_50");
    chk_mem(16'hFE9F, 8'h60, "t4_oam_last");

    // 5: echo-RAM source page FE -> DE
    cpu_wr(16'hFF46, 8'hFE);
    cpu_rd(16'hFF46, 8'hFE, "t5_reg_during");
    wait_idle("t5_done");
    chk_mem(16'hFE00, 8'h10, "t5_oam_first");
    chk_mem(16'hFE50, 8'h60, "t5_oam_80");
    chk_mem(16'hFE9F, 8'hAF, "t5_oam_last");
    cpu_rd(16'hFF46, 8'hFE, "t5_reg_after");

    // 6: reset while reading byte 80
    cpu_wr(16'hFF46, 8'hC2);
    tick(161);
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    oam_wr_cnt = 0;
    chk_active(1'b0, "t6_abort_active");
    cpu_rd(16'hFF46, 8'hFF, "t6_dma_reg_rst");
    cpu_wr(16'h0200, 8'h33);
    chk_mem(16'h0200, 8'h33, "t6_pass_wr");
    tick(5);
    expect_val(K_OAMWR, 16'h0000, 16'd0, "t6_no_oam_writes");
    tick();
    chk_mem(16'hFE00, 8'h40, "t6_oam_first");
    chk_mem(16'hFE4F, 8'h8F, "t6_oam_79");
    chk_mem(16'hFE50, 8'h60, "t6_oam_80_untouched");
    chk_mem(16'hFE9F, 8'hAF, "t6_oam_last_untouched");

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
